// File: rtl/upc_stack.sv
// upc_stack: Am2910-style LIFO microprogram stack (F next-address source).
// Optional sticky overflow/underflow flag on err when UPC_STACK_ERR_EN is defined.
module upc_stack #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 5,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic [PTR_W-1:0] sp,
`ifdef UPC_STACK_ERR_EN
    output logic             err,
`endif
    output logic             empty,
    output logic             full_n
);

    localparam logic [PTR_W-1:0] SP_MAX = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] SP_ONE = PTR_W'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] sp_q, sp_d;
    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;
    logic             is_empty, is_full;

    assign is_empty = (sp_q == '0);
    assign is_full  = (sp_q == SP_MAX);

    always_comb begin
        sp_d   = sp_q;
        wr_en  = 1'b0;
        wr_idx = sp_q;
        if (clear) begin
            sp_d = '0;
        end else if (push && pop && !is_empty) begin
            // Replace top in place; pointer unchanged
            wr_en  = 1'b1;
            wr_idx = sp_q - SP_ONE;
        end else if (push) begin
            wr_en = 1'b1;
            if (is_full) begin
                wr_idx = SP_MAX - SP_ONE;
            end else begin
                wr_idx = sp_q;
                sp_d   = sp_q + SP_ONE;
            end
        end else if (pop) begin
            if (!is_empty) begin
                sp_d = sp_q - SP_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            sp_q <= sp_d;
            if (wr_en) begin
                mem_q[wr_idx] <= push_data;
            end
        end
    end

    assign top    = is_empty ? '0 : mem_q[sp_q - SP_ONE];
    assign sp     = sp_q;
    assign empty  = is_empty;
    assign full_n = ~is_full;

`ifdef UPC_STACK_ERR_EN
    logic err_q, err_d;
    logic ovf, unf;

    assign ovf = push & ~pop & is_full;
    assign unf = pop & ~push & is_empty;

    always_comb begin
        err_d = err_q;
        if (clear) begin
            err_d = 1'b0;
        end else if (ovf || unf) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: doc/upc_stack.md
Name: upc_stack

Overview:
- LIFO microprogram stack that produces the stack (F) next-address source of the sequencer's next-address select.
- Default is 5 entries of 12 bits, matching the Am2910 file.
- Holds return addresses for subroutine calls and loop start addresses.
- The instruction decoder drives the push, pop and clear strobes. The block exposes the top of stack plus full and empty status.

Parameters:
- WIDTH, 12, address width in bits.
- DEPTH, 5, number of stack entries.
- PTR_W, 3, stack-pointer width; must satisfy 2^PTR_W > DEPTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous stack clear (sp <= 0).
- push  input  1  push push_data.
- pop  input  1  pop the top entry.
- push_data  input  WIDTH  address to push (uPC value).
- top  output  WIDTH  current top of stack (F source for the next-address select).
- sp  output  PTR_W  current depth, range 0..DEPTH.
- empty  output  1  high when sp == 0.
- full_n  output  1  low when sp == DEPTH (Am2910 FULL active-low).
- err  output  1  sticky overflow/underflow flag; present only with the optional feature.

Behaviour:
- Reset (rst_n low, asynchronous):
  - sp = 0; all entries cleared to 0.
  - Outputs: top = 0, empty = 1, full_n = 1, err = 0.
- Storage: DEPTH x WIDTH register array; entry index 0 is the bottom.
- top is combinational from registered state: mem[sp-1] when sp > 0, else 0.
  - A push or pop is therefore visible on top in the cycle after the edge (1-cycle latency).
- empty = (sp == 0); full_n = ~(sp == DEPTH). Both are combinational from sp.
- Per-edge priority (highest first):
  1. clear: sp <= 0. Array contents are untouched. push and pop are ignored that cycle.
  2. push and pop both high (replace top):
     - If sp > 0: mem[sp-1] <= push_data; sp unchanged.
     - If sp == 0: behaves as a plain push.
  3. push only:
     - If sp < DEPTH: mem[sp] <= push_data; sp <= sp + 1.
     - If sp == DEPTH (overflow): mem[DEPTH-1] <= push_data; sp stays DEPTH. This is the Am2910 overwrite-top behaviour.
  4. pop only:
     - If sp > 0: sp <= sp - 1. The entry is not cleared.
     - If sp == 0 (underflow): no change; top stays 0.
  5. None asserted: hold.
- The pointer never leaves 0..DEPTH and never wraps.
- Entries above sp keep stale data; top never exposes them.
- Reset asserted mid-operation overrides everything immediately. After release, the first edge acts on the strobes present.
- The block has no internal FSM beyond the pointer. The pointer itself is the state, with DEPTH+1 legal values.

Optional Feature:
- Macro: UPC_STACK_ERR_EN.
- Defined:
  - err port and a sticky error register exist.
  - err <= 1 on any overflow push (push only, sp == DEPTH) or underflow pop (pop only, sp == 0).
  - Cleared only by rst_n or clear. clear takes priority over setting the flag in the same cycle.
  - All other behaviour is unchanged.
- Not defined: err port and its logic are absent. Overflow and underflow behave as above with no indication.

Test Plan:
1. Reset, then idle -> sp = 0, empty = 1, full_n = 1, top = 0x000 (err = 0 if enabled).
2. Push 0x101, 0x202, 0x303, 0x404, 0x505 on consecutive cycles:
   - After each edge, sp increments and top equals the last value pushed.
   - After the 5th push: sp = 5, full_n = 0, top = 0x505.
3. From full, push 0xABC:
   - sp = 5, top = 0xABC.
   - Pop once -> top = 0x404, sp = 4, full_n = 1 (err = 1 if enabled).
4. From sp = 2 (top 0x202), assert push and pop together with 0x777:
   - sp = 2, top = 0x777.
   - Pop -> top = 0x101.
5. Pop until empty, then one more pop:
   - sp = 0, empty = 1, top = 0x000, no pointer wrap (err = 1 if enabled).
6. From sp = 3, assert clear with push = 1 and push_data = 0x3FF:
   - sp = 0, empty = 1, err = 0.
   - Next push of 0x0AA -> sp = 1, top = 0x0AA.
   - Then drop rst_n mid-cycle -> all outputs return to reset values before the next edge.
